resp_checker: RTL and testbench
===============================

Name: resp_checker

Overview:
- Hardware response checker: the receiving/compare end of the datapath vector protocol.
- Holds up to DEPTH expected DATA_WIDTH-bit responses, loaded before a run.
- During a run, compares each valid DUT response in order against the stored expectations, counts vectors and mismatches, and flags completion.
- Sits beside a datapath unit under test (flopr, alu, regfile) for on-chip self-check.

Parameters:
- DATA_WIDTH, 64, width of responses and expected values
- DEPTH, 16, number of expected-vector entries
- ADDR_W, 4, index width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- load_we  input  1  write expected entry; honoured only in IDLE or DONE
- load_addr  input  ADDR_W  expected-entry index
- load_data  input  DATA_WIDTH  expected value
- start  input  1  begin run; sampled in IDLE or DONE
- num_vecs  input  ADDR_W+1  vectors in run, sampled with start
- resp_valid  input  1  resp_data valid this cycle
- resp_data  input  DATA_WIDTH  DUT response (e.g. flopr q)
- busy  output  1  high in RUN
- done  output  1  high in DONE
- mismatch  output  1  one-cycle pulse, registered, the cycle after a failing compare
- err_count  output  32  mismatches this run, saturating
- vec_count  output  32  responses compared this run
- first_err_valid  output  1  at least one mismatch this run
- first_err_idx  output  ADDR_W  index of first mismatch

Behaviour:
- Reset:
  - state=IDLE; busy, done, mismatch, first_err_valid = 0; err_count, vec_count, first_err_idx = 0; internal idx=0.
  - Expected memory is not cleared.
- States IDLE, RUN, DONE:
  - IDLE/DONE + start:
    - clear counters, idx, first_err_*.
    - n = min(num_vecs, DEPTH).
    - n=0 -> DONE next cycle.
    - Else -> RUN next cycle.
  - RUN:
    - Each cycle with resp_valid: compare resp_data to mem[idx]; vec_count+1; on inequality err_count+1 (hold at 32'hFFFFFFFF) and mismatch=1 next cycle.
    - On the first mismatch, first_err_idx=idx and first_err_valid=1.
    - idx+1.
    - Accepting the compare at idx=n-1 -> DONE next cycle.
    - Cycles without resp_valid hold all state.
  - DONE: done=1 and all results held until start or reset.
- Compare latency: counters and mismatch update one cycle after the resp_valid cycle; no backpressure, checker accepts every cycle.
- load_we:
  - In RUN: ignored.
  - In IDLE/DONE with load_addr >= DEPTH: ignored.
  - Simultaneous with start in the same cycle: the write occurs and the start is honoured; the written value is visible from the first RUN cycle.
- start:
  - In RUN: ignored.
  - In DONE: restarts with cleared results.
- resp_valid outside RUN: ignored, no count change.
- Reset mid-RUN: abort to IDLE, results cleared, memory retained.
- Comparison is 2-state equality on all DATA_WIDTH bits.

Optional Feature:
- Macro RESP_CHK_MASK_EN.
- Defined:
  - Adds input load_mask [DATA_WIDTH-1:0] and a mask memory written alongside load_data.
  - Compare is ((resp_data ^ mem[idx]) & mask[idx]) != 0.
  - A mask bit of 0 marks a don't-care bit.
  - Mask memory resets to all ones.
- Not defined: no load_mask port, full-width compare, no mask storage.

Test Plan:
- Load expected {0,11,20,25,30,35} at 0..5, start num_vecs=6, drive matching responses on 6 consecutive cycles -> done=1, vec_count=6, err_count=0, first_err_valid=0, mismatch never pulses.
- Same load, responses with entry 3 = 26 -> mismatch pulses once, err_count=1, first_err_idx=3, done after 6 compares.
- start num_vecs=0 -> DONE next cycle, counts 0. Then start num_vecs=20 with DEPTH=16 -> run stops after 16 compares.
- Gaps: resp_valid toggled 1,0,0,1,... over 4 vectors -> counts advance only on valid cycles; done after 4th valid.
- Reset asserted after 2 of 6 compares -> IDLE, counters 0. Restart without reload -> original expectations still match, err_count=0.
- RESP_CHK_MASK_EN: entry 0 expect 64'hFF, mask 64'hF0, response 64'hF3 -> err_count=0; without the macro -> err_count=1.

Source files
------------

// File: rtl/resp_checker.sv
// Response checker: compares in-order DUT responses against a preloaded table of expected values.
// Optional RESP_CHK_MASK_EN adds a per-entry compare mask (mask bit 0 = don't care).
module resp_checker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_we,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
`ifdef RESP_CHK_MASK_EN
  input  logic [DATA_WIDTH-1:0] load_mask,
`endif
  input  logic                  start,
  input  logic [ADDR_W:0]       num_vecs,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic [31:0]           err_count,
  output logic [31:0]           vec_count,
  output logic                  first_err_valid,
  output logic [ADDR_W-1:0]     first_err_idx
);

  localparam int unsigned NW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     idx;
  logic [NW-1:0]         n_vecs;

  logic                  load_ok_c;
  logic                  miss_c;
  logic                  last_c;
  logic [NW-1:0]         n_start_c;

  assign load_ok_c = load_we && (state != RUN) && (32'(load_addr) < DEPTH);
  assign n_start_c = (32'(num_vecs) > DEPTH) ? NW'(DEPTH) : num_vecs;
  assign last_c    = (NW'(idx) == (n_vecs - NW'(1)));

  // Expected values survive reset; only loads change them.
  always_ff @(posedge clk) begin
    if (load_ok_c) mem[load_addr] <= load_data;
  end

`ifdef RESP_CHK_MASK_EN
  logic [DATA_WIDTH-1:0] mask_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mask_mem[i] <= '1;
    end else if (load_ok_c) begin
      mask_mem[load_addr] <= load_mask;
    end
  end

  assign miss_c = ((resp_data ^ mem[idx]) & mask_mem[idx]) != '0;
`else
  assign miss_c = (resp_data != mem[idx]);
`endif

  // Run control, counters and first-error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      idx             <= '0;
      n_vecs          <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count       <= '0;
            vec_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            idx             <= '0;
            n_vecs          <= n_start_c;
            if (n_start_c == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (resp_valid) begin
            vec_count <= vec_count + 32'd1;
            if (miss_c) begin
              mismatch <= 1'b1;
              if (err_count != '1) err_count <= err_count + 32'd1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= idx;
              end
            end
            idx <= idx + ADDR_W'(1);
            if (last_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker: directed table, multi-cycle corner sequences, randomized runs.
module tb_resp_checker;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] load_mask;
  logic          start;
  logic [AW:0]   num_vecs;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          busy, done, mismatch, first_err_valid;
  logic [31:0]   err_count, vec_count;
  logic [AW-1:0] first_err_idx;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] model [DEPTH];

  resp_checker dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`ifdef RESP_CHK_MASK_EN
    .load_mask(load_mask),
`endif
    .start(start), .num_vecs(num_vecs), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count), .vec_count(vec_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    load_we = 1'b1; load_addr = AW'(a); load_data = d; load_mask = m;
    step();
    load_we = 1'b0; load_mask = '1;
    model[a] = d;
  endtask

  // Start a run, feed responses (bad[k] -> expected+1), check per-cycle counters and final results.
  task automatic run_check(input string tag, input int num, input logic [15:0] bad, input int gap_mode,
                           input int exp_vec, input int exp_err, input bit exp_fev, input int exp_fidx);
    int k, cyc, pulses;
    bit v, exp_m;
    start = 1'b1; num_vecs = 5'(num);
    step();
    start = 1'b0;
    chk({tag, ".busy0"}, 64'(busy), 64'(exp_vec > 0));
    chk({tag, ".done0"}, 64'(done), 64'(exp_vec == 0));
    k = 0; cyc = 0; pulses = 0;
    while (!done && cyc < 100) begin
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = (cyc % 3 == 0);
      else                    v = ($urandom_range(0, 3) != 0);
      resp_valid = v;
      resp_data  = bad[k % 16] ? model[k % 16] + 64'd1 : model[k % 16];
      exp_m      = v ? bad[k % 16] : 1'b0;
      step();
      if (v) k++;
      cyc++;
      pulses += int'(mismatch);
      chk({tag, ".vec_step"}, 64'(vec_count), 64'(k));
      chk({tag, ".mm_step"}, 64'(mismatch), 64'(exp_m));
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    // Responses after completion must be ignored.
    resp_valid = 1'b1; resp_data = ~model[0];
    step(); pulses += int'(mismatch);
    step(); pulses += int'(mismatch);
    resp_valid = 1'b0;
    chk({tag, ".vec"}, 64'(vec_count), 64'(exp_vec));
    chk({tag, ".err"}, 64'(err_count), 64'(exp_err));
    chk({tag, ".fev"}, 64'(first_err_valid), 64'(exp_fev));
    if (exp_fev) chk({tag, ".fidx"}, 64'(first_err_idx), 64'(exp_fidx));
    chk({tag, ".pulses"}, 64'(pulses), 64'(exp_err));
    chk({tag, ".done_hold"}, 64'(done), 64'd1);
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          num;
    logic [15:0] bad;
    int          gap;
    int          vec;
    int          err;
    bit          fev;
    int          fidx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, e, f;
    logic [15:0] bad;
    logic [63:0] base [6];

    tbl[0] = '{num: 6,  bad: 16'h0000, gap: 0, vec: 6,  err: 0, fev: 1'b0, fidx: 0};
    tbl[1] = '{num: 6,  bad: 16'h0008, gap: 0, vec: 6,  err: 1, fev: 1'b1, fidx: 3};
    tbl[2] = '{num: 0,  bad: 16'h0000, gap: 0, vec: 0,  err: 0, fev: 1'b0, fidx: 0};
    tbl[3] = '{num: 20, bad: 16'h8000, gap: 0, vec: 16, err: 1, fev: 1'b1, fidx: 15};
    tbl[4] = '{num: 4,  bad: 16'h0000, gap: 1, vec: 4,  err: 0, fev: 1'b0, fidx: 0};
    tbl[5] = '{num: 6,  bad: 16'h0026, gap: 1, vec: 6,  err: 3, fev: 1'b1, fidx: 1};

    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; load_mask = '1;
    start = 1'b0; num_vecs = '0; resp_valid = 1'b0; resp_data = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.mismatch", 64'(mismatch), 64'd0);
    chk("rst.err", 64'(err_count), 64'd0);
    chk("rst.vec", 64'(vec_count), 64'd0);
    chk("rst.fev", 64'(first_err_valid), 64'd0);
    chk("rst.fidx", 64'(first_err_idx), 64'd0);

    // Responses before any run are ignored.
    resp_valid = 1'b1; resp_data = 64'hDEAD;
    step();
    resp_valid = 1'b0;
    chk("idle.vec", 64'(vec_count), 64'd0);

    base[0] = 64'd0; base[1] = 64'd11; base[2] = 64'd20;
    base[3] = 64'd25; base[4] = 64'd30; base[5] = 64'd35;
    for (int i = 0; i < DEPTH; i++)
      load(i, (i < 6) ? base[i] : {$urandom, $urandom}, '1);

    for (int t = 0; t < 6; t++)
      run_check($sformatf("tbl%0d", t), tbl[t].num, tbl[t].bad, tbl[t].gap,
                tbl[t].vec, tbl[t].err, tbl[t].fev, tbl[t].fidx);

    // Reset mid-run aborts; expectations stay loaded.
    start = 1'b1; num_vecs = 5'd6;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1; resp_data = model[i];
      step();
    end
    resp_valid = 1'b0;
    chk("midrst.vec_pre", 64'(vec_count), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.vec", 64'(vec_count), 64'd0);
    chk("midrst.err", 64'(err_count), 64'd0);
    run_check("rerun", 6, 16'h0000, 0, 6, 0, 1'b0, 0);

    // start and load_we are ignored while running.
    start = 1'b1; num_vecs = 5'd6;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      resp_valid = 1'b1; resp_data = model[i];
      if (i == 2) begin
        start = 1'b1; num_vecs = 5'd2;
        load_we = 1'b1; load_addr = 4'd5; load_data = 64'd999;
      end
      step();
      start = 1'b0; load_we = 1'b0;
    end
    resp_valid = 1'b0;
    chk("runign.done", 64'(done), 64'd1);
    chk("runign.vec", 64'(vec_count), 64'd6);
    chk("runign.err", 64'(err_count), 64'd0);
    run_check("runign.post", 6, 16'h0000, 0, 6, 0, 1'b0, 0);

    // Load simultaneous with start is visible from the first compare.
    load_we = 1'b1; load_addr = 4'd0; load_data = 64'h1234; load_mask = '1;
    start = 1'b1; num_vecs = 5'd1;
    step();
    load_we = 1'b0; start = 1'b0;
    model[0] = 64'h1234;
    resp_valid = 1'b1; resp_data = 64'h1234;
    step();
    resp_valid = 1'b0;
    chk("ldstart.done", 64'(done), 64'd1);
    chk("ldstart.vec", 64'(vec_count), 64'd1);
    chk("ldstart.err", 64'(err_count), 64'd0);

    // Masked compare: only the upper nibble of the byte matters when masking is built in.
    load(0, 64'hFF, 64'hF0);
    start = 1'b1; num_vecs = 5'd1;
    step();
    start = 1'b0;
    resp_valid = 1'b1; resp_data = 64'hF3;
    step();
    resp_valid = 1'b0;
`ifdef RESP_CHK_MASK_EN
    chk("mask.err", 64'(err_count), 64'd0);
`else
    chk("mask.err", 64'(err_count), 64'd1);
`endif
    load(0, 64'd0, '1);

    // Randomized runs against the reference rules.
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 3; j++) load($urandom_range(0, DEPTH - 1), {$urandom, $urandom}, '1);
      n   = $urandom_range(0, 20);
      bad = 16'($urandom);
      if (n > DEPTH) n = DEPTH;
      e = 0; f = -1;
      for (int i = 0; i < n; i++) if (bad[i]) begin
        e++;
        if (f < 0) f = i;
      end
      run_check($sformatf("rnd%0d", r), $urandom_range(n, (n == DEPTH) ? 20 : n), bad, 2,
                n, e, (e > 0), (f < 0) ? 0 : f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
